// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle for mem_bus_arbiter: two requester channels (fetch, load/store)
// plus the single memory slave port. The master modport is the arbiter's view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_done;
  logic              m0_err;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_write;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_done;
  logic              m1_err;

  logic              HSel;
  logic [ADDR_W-1:0] HAddress;
  logic [DATA_W-1:0] HWrite_data;
  logic              HWrite;
  logic [DATA_W-1:0] HRead_data;
  logic              HReady;
  logic [1:0]        HResp;

  modport master (
    input  m0_req, m0_addr, m1_req, m1_addr, m1_wdata, m1_write,
    input  HRead_data, HReady, HResp,
    output m0_rdata, m0_done, m0_err, m1_rdata, m1_done, m1_err,
    output HSel, HAddress, HWrite_data, HWrite
  );

  modport slave (
    output m0_req, m0_addr, m1_req, m1_addr, m1_wdata, m1_write,
    output HRead_data, HReady, HResp,
    input  m0_rdata, m0_done, m0_err, m1_rdata, m1_done, m1_err,
    input  HSel, HAddress, HWrite_data, HWrite
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer (fetch = m0, load/store = m1) for one memory slave port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on ties instead of fixed m0 priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  mem_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic              owner_q;
  logic [7:0]        cnt_q;
  logic              HSel_q;
  logic [ADDR_W-1:0] HAddress_q;
  logic [DATA_W-1:0] HWrite_data_q;
  logic              HWrite_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              m0_done_q, m0_err_q, m1_done_q, m1_err_q;

  logic anyReq;
  logic grantM1;

  assign anyReq = bus.m0_req | bus.m1_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rrPtr_q names the master that wins the next tie; it flips to the loser on every grant.
  logic rrPtr_q;
  logic rrPtr_d;

  assign grantM1 = bus.m1_req & (~bus.m0_req | rrPtr_q);
  assign rrPtr_d = ~grantM1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr_q <= 1'b0;
    end else if (state_q == IDLE && anyReq) begin
      rrPtr_q <= rrPtr_d;
    end
  end
`else
  assign grantM1 = bus.m1_req & ~bus.m0_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      cnt_q         <= '0;
      HSel_q        <= 1'b0;
      HAddress_q    <= '0;
      HWrite_data_q <= '0;
      HWrite_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      m0_done_q     <= 1'b0;
      m0_err_q      <= 1'b0;
      m1_done_q     <= 1'b0;
      m1_err_q      <= 1'b0;
    end else begin
      m0_done_q <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_done_q <= 1'b0;
      m1_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            owner_q       <= grantM1;
            HAddress_q    <= grantM1 ? bus.m1_addr : bus.m0_addr;
            HWrite_data_q <= grantM1 ? bus.m1_wdata : '0;
            HWrite_q      <= grantM1 & bus.m1_write;
            HSel_q        <= 1'b1;
            state_q       <= ADDR;
          end
        end
        ADDR: begin
          cnt_q   <= '0;
          state_q <= DATA;
        end
        DATA: begin
          // HReady is checked before the timeout so a late response still completes normally.
          if (bus.HReady) begin
            HSel_q  <= 1'b0;
            state_q <= IDLE;
            if (owner_q) begin
              m1_done_q <= 1'b1;
              m1_err_q  <= (bus.HResp != 2'b00);
              if (!HWrite_q) m1_rdata_q <= bus.HRead_data;
            end else begin
              m0_done_q <= 1'b1;
              m0_err_q  <= (bus.HResp != 2'b00);
              if (!HWrite_q) m0_rdata_q <= bus.HRead_data;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            HSel_q  <= 1'b0;
            state_q <= IDLE;
            if (owner_q) begin
              m1_done_q <= 1'b1;
              m1_err_q  <= 1'b1;
            end else begin
              m0_done_q <= 1'b1;
              m0_err_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          HSel_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.HSel        = HSel_q;
  assign bus.HAddress    = HAddress_q;
  assign bus.HWrite_data = HWrite_data_q;
  assign bus.HWrite      = HWrite_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m0_done     = m0_done_q;
  assign bus.m0_err      = m0_err_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign bus.m1_done     = m1_done_q;
  assign bus.m1_err      = m1_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: read, write with waits, contention, error,
// timeout and mid-transfer reset, with hand-computed expectations.
module tb_mem_bus_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   hselCount;
  logic [31:0] lastM0Rdata;
  logic [31:0] lastM1Rdata;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic m0Req, input logic [31:0] m0Addr,
                               input logic m1Req, input logic [31:0] m1Addr,
                               input logic [31:0] m1Wdata, input logic m1Write,
                               input logic hReady, input logic [31:0] hReadData,
                               input logic [1:0] hResp);
    bus.m0_req     = m0Req;
    bus.m0_addr    = m0Addr;
    bus.m1_req     = m1Req;
    bus.m1_addr    = m1Addr;
    bus.m1_wdata   = m1Wdata;
    bus.m1_write   = m1Write;
    bus.HReady     = hReady;
    bus.HRead_data = hReadData;
    bus.HResp      = hResp;
  endtask

  // Advance one rising edge and settle; also tallies cycles with HSel high.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.HSel === 1'b1) hselCount++;
  endtask

  initial begin
    int expOwner;
    errors      = 0;
    checks      = 0;
    hselCount   = 0;
    lastM0Rdata = 32'h0;
    lastM1Rdata = 32'h0;
    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_hsel", bus.HSel, 0);
    checkOutput("reset_haddr", bus.HAddress, 0);
    checkOutput("reset_m0_done", bus.m0_done, 0);
    checkOutput("reset_m1_rdata", bus.m1_rdata, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("idle_hsel", bus.HSel, 0);

    $display("[TB] single read m0");
    applyStimulus(1, 32'h100, 0, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF, 2'b00);
    hselCount = 0;
    tick();
    checkOutput("rd_addr_hsel", bus.HSel, 1);
    checkOutput("rd_haddr", bus.HAddress, 32'h100);
    checkOutput("rd_hwrite", bus.HWrite, 0);
    checkOutput("rd_early_done", bus.m0_done, 0);
    tick();
    checkOutput("rd_data_hsel", bus.HSel, 1);
    checkOutput("rd_data_done", bus.m0_done, 0);
    tick();
    checkOutput("rd_done", bus.m0_done, 1);
    checkOutput("rd_rdata", bus.m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_err", bus.m0_err, 0);
    checkOutput("rd_m1_done", bus.m1_done, 0);
    checkOutput("rd_hsel_count", hselCount, 2);
    lastM0Rdata = 32'hDEADBEEF;
    applyStimulus(0, 32'h100, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);
    tick();
    checkOutput("rd_done_pulse", bus.m0_done, 0);
    checkOutput("rd_rdata_held", bus.m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_idle_hsel", bus.HSel, 0);

    $display("[TB] m1 write with three wait states");
    applyStimulus(0, 32'h0, 1, 32'h20, 32'h12345678, 1, 0, 32'hAAAA5555, 2'b00);
    hselCount = 0;
    tick();
    checkOutput("wr_haddr", bus.HAddress, 32'h20);
    checkOutput("wr_hwrite", bus.HWrite, 1);
    checkOutput("wr_hwdata", bus.HWrite_data, 32'h12345678);
    tick();
    tick();
    tick();
    tick();
    checkOutput("wr_wait_done", bus.m1_done, 0);
    checkOutput("wr_wait_hwdata", bus.HWrite_data, 32'h12345678);
    checkOutput("wr_wait_hwrite", bus.HWrite, 1);
    bus.HReady = 1'b1;
    tick();
    checkOutput("wr_done", bus.m1_done, 1);
    checkOutput("wr_err", bus.m1_err, 0);
    checkOutput("wr_rdata_unchanged", bus.m1_rdata, lastM1Rdata);
    checkOutput("wr_m0_done", bus.m0_done, 0);
    checkOutput("wr_hsel_count", hselCount, 5);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);
    tick();
    checkOutput("wr_done_pulse", bus.m1_done, 0);

    $display("[TB] contention");
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expOwner = k % 2;
`else
      expOwner = 0;
`endif
      applyStimulus(1, 32'h300, 1, 32'h40, 32'h0, 0, 1, 32'h1000 + 32'(k), 2'b00);
      tick();
      checkOutput($sformatf("cont%0d_haddr", k), bus.HAddress, (expOwner == 1) ? 32'h40 : 32'h300);
      tick();
      tick();
      checkOutput($sformatf("cont%0d_m0_done", k), bus.m0_done, (expOwner == 0) ? 1 : 0);
      checkOutput($sformatf("cont%0d_m1_done", k), bus.m1_done, (expOwner == 1) ? 1 : 0);
      if (expOwner == 0) lastM0Rdata = 32'h1000 + 32'(k);
      else lastM1Rdata = 32'h1000 + 32'(k);
    end
    checkOutput("cont_m0_rdata", bus.m0_rdata, lastM0Rdata);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);
    tick();
    checkOutput("cont_idle_hsel", bus.HSel, 0);

    $display("[TB] error response");
    applyStimulus(0, 32'h0, 1, 32'h50, 32'h0, 0, 1, 32'h55AA55AA, 2'b01);
    tick();
    tick();
    tick();
    checkOutput("err_done", bus.m1_done, 1);
    checkOutput("err_flag", bus.m1_err, 1);
    checkOutput("err_m0_err", bus.m0_err, 0);
    checkOutput("err_rdata", bus.m1_rdata, 32'h55AA55AA);
    lastM1Rdata = 32'h55AA55AA;
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);
    tick();
    checkOutput("err_flag_clear", bus.m1_err, 0);

    $display("[TB] timeout");
    applyStimulus(1, 32'h60, 0, 32'h0, 32'h0, 0, 0, 32'h77777777, 2'b00);
    tick();
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      checkOutput($sformatf("to_wait%0d_done", i), bus.m0_done, 0);
    end
    checkOutput("to_wait_hsel", bus.HSel, 1);
    tick();
    checkOutput("to_done", bus.m0_done, 1);
    checkOutput("to_err", bus.m0_err, 1);
    checkOutput("to_rdata_unchanged", bus.m0_rdata, lastM0Rdata);
    checkOutput("to_hsel_off", bus.HSel, 0);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);
    tick();

    $display("[TB] reset during DATA");
    applyStimulus(0, 32'h0, 1, 32'h70, 32'h0, 0, 0, 32'h0, 2'b00);
    tick();
    tick();
    checkOutput("rst_pre_hsel", bus.HSel, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_hsel", bus.HSel, 0);
    checkOutput("rst_m0_rdata", bus.m0_rdata, 0);
    checkOutput("rst_m1_rdata", bus.m1_rdata, 0);
    checkOutput("rst_m1_done", bus.m1_done, 0);
    applyStimulus(0, 32'h0, 1, 32'h80, 32'h0, 0, 1, 32'hCAFEF00D, 2'b00);
    tick();
    checkOutput("rst_hold_hsel", bus.HSel, 0);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_haddr", bus.HAddress, 32'h80);
    tick();
    tick();
    checkOutput("post_rst_done", bus.m1_done, 1);
    checkOutput("post_rst_rdata", bus.m1_rdata, 32'hCAFEF00D);
    checkOutput("post_rst_err", bus.m1_err, 0);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
